// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between the CPU and the debug port.
// Optional build macro ARB_FAIR_EN: alternate grants when both ports contend.
module mem_arbiter #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_valid,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_wstrb,
    output logic        dbg_ready,
    output logic [31:0] dbg_rdata,
    input  logic        dbg_halt,
    output logic        cpu_halted,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DBG_XFER = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_own_dbg;
    logic [15:0] r_cnt;
    logic        w_grant_cpu;
    logic        w_grant_dbg;
    logic        w_xfer;
    logic        w_abort;
    logic        w_done;

    assign w_xfer  = (r_state == CPU_XFER) || (r_state == DBG_XFER);
    assign w_abort = w_xfer && !mem_ready && (r_cnt == CNT_LAST);
    assign w_done  = w_xfer && (mem_ready || w_abort);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_cpu = 1'b0;
        w_grant_dbg = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef ARB_FAIR_EN
                // r_own_dbg still holds the previous owner, so it doubles as the fairness flag.
                if (dbg_valid && cpu_valid && !dbg_halt && r_own_dbg) begin
                    w_grant_cpu = 1'b1;
                end else if (dbg_valid) begin
                    w_grant_dbg = 1'b1;
                end else if (cpu_valid && !dbg_halt) begin
                    w_grant_cpu = 1'b1;
                end
`else
                if (dbg_valid) begin
                    w_grant_dbg = 1'b1;
                end else if (cpu_valid && !dbg_halt) begin
                    w_grant_cpu = 1'b1;
                end
`endif
                if (w_grant_dbg) begin
                    w_next = DBG_XFER;
                end else if (w_grant_cpu) begin
                    w_next = CPU_XFER;
                end
            end
            CPU_XFER, DBG_XFER: begin
                if (w_done) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_own_dbg   <= 1'b0;
            r_cnt       <= '0;
            mem_valid   <= 1'b0;
            mem_instr   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
            timeout_err <= 1'b0;
        end else if (w_grant_dbg || w_grant_cpu) begin
            r_own_dbg <= w_grant_dbg;
            r_cnt     <= '0;
            mem_valid <= 1'b1;
            mem_instr <= w_grant_dbg ? 1'b0      : cpu_instr;
            mem_addr  <= w_grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= w_grant_dbg ? dbg_wdata : cpu_wdata;
            mem_wstrb <= w_grant_dbg ? dbg_wstrb : cpu_wstrb;
        end else if (w_done) begin
            mem_valid <= 1'b0;
            if (r_own_dbg) begin
                dbg_rdata <= mem_ready ? mem_rdata : ERR_RDATA;
            end else begin
                cpu_rdata <= mem_ready ? mem_rdata : ERR_RDATA;
            end
            if (!mem_ready) begin
                timeout_err <= 1'b1;
            end
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign cpu_ready  = (r_state == RESP) && !r_own_dbg;
    assign dbg_ready  = (r_state == RESP) &&  r_own_dbg;
    // Halted only once no CPU transfer (including its response cycle) is in flight.
    assign cpu_halted = dbg_halt && (r_state != CPU_XFER)
                        && !((r_state == RESP) && !r_own_dbg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then random traffic
// checked against a transaction-level arbitration and memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid, cpu_instr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        dbg_valid;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [3:0]  dbg_wstrb;
    logic        dbg_ready;
    logic [31:0] dbg_rdata;
    logic        dbg_halt, cpu_halted;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_wstrb(dbg_wstrb), .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
        .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Memory model: answers after a (possibly random) wait, writes only when it answers.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit mem_hold = 1'b0;
    bit rand_wait = 1'b0;
    int wcnt = 0;
    int cur_wait = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (mem_valid && !mem_ready && !mem_hold) begin
            if (wcnt >= cur_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                if (mem_wstrb != 4'd0) mem[mem_addr] = merge(mem_rd(mem_addr), mem_wdata, mem_wstrb);
            end else begin
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
            cur_wait = rand_wait ? int'($urandom_range(0, 3)) : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input bit is_dbg, input int budget, input string tag);
        int k = 0;
        while (!(is_dbg ? dbg_ready : cpu_ready) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, is_dbg ? dbg_ready : cpu_ready}, 32'd1);
    endtask

    // Random-phase model state
    bit last_dbg = 1'b0;
    bit prev_mv = 1'b0;
    int n_done = 0;

    task automatic new_cpu();
        cpu_valid = 1'b1;
        cpu_addr  = 32'h600 + 32'(4 * $urandom_range(0, 7));
        cpu_wdata = $urandom;
        cpu_wstrb = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
        cpu_instr = (cpu_wstrb == 4'd0) ? 1'($urandom % 2) : 1'b0;
    endtask

    task automatic new_dbg();
        dbg_valid = 1'b1;
        dbg_addr  = 32'h600 + 32'(4 * $urandom_range(0, 7));
        dbg_wdata = $urandom;
        dbg_wstrb = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
    endtask

    task automatic rnd_cycle(input bit allow_new);
        bit exp_dbg;
        chk("rnd_one_ready", {31'd0, cpu_ready & dbg_ready}, 32'd0);
        if (mem_valid && !prev_mv) begin
            if (cpu_valid && dbg_valid) begin
`ifdef ARB_FAIR_EN
                exp_dbg = !last_dbg;
`else
                exp_dbg = 1'b1;
`endif
            end else begin
                exp_dbg = dbg_valid;
                if (!cpu_valid && !dbg_valid) chk("rnd_spurious_grant", 32'd1, 32'd0);
            end
            chk("rnd_grant_addr", mem_addr, exp_dbg ? dbg_addr : cpu_addr);
            chk("rnd_grant_wdata", mem_wdata, exp_dbg ? dbg_wdata : cpu_wdata);
            chk("rnd_grant_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_dbg ? dbg_wstrb : cpu_wstrb});
            chk("rnd_grant_instr", {31'd0, mem_instr}, {31'd0, exp_dbg ? 1'b0 : cpu_instr});
            last_dbg = exp_dbg;
        end
        prev_mv = mem_valid;
        if (cpu_ready) begin
            chk("rnd_cpu_rdata", cpu_rdata, ref_rd(cpu_addr));
            if (cpu_wstrb != 4'd0) ref_mem[cpu_addr] = merge(ref_rd(cpu_addr), cpu_wdata, cpu_wstrb);
            n_done++;
            if (allow_new && $urandom % 2 == 0) new_cpu(); else cpu_valid = 1'b0;
        end else if (allow_new && !cpu_valid && $urandom % 4 == 0) begin
            new_cpu();
        end
        if (dbg_ready) begin
            chk("rnd_dbg_rdata", dbg_rdata, ref_rd(dbg_addr));
            if (dbg_wstrb != 4'd0) ref_mem[dbg_addr] = merge(ref_rd(dbg_addr), dbg_wdata, dbg_wstrb);
            n_done++;
            if (allow_new && $urandom % 2 == 0) new_dbg(); else dbg_valid = 1'b0;
        end else if (allow_new && !dbg_valid && $urandom % 4 == 0) begin
            new_dbg();
        end
        tick();
    endtask

    initial begin
        int n_dbg;
        resetn = 1'b0; dbg_halt = 1'b0;
        cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0;
        mem[32'h100] = 32'h12345678;
        tick(); tick();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_dbg_ready", {31'd0, dbg_ready}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_cpu_halted", {31'd0, cpu_halted}, 32'd0);
        resetn = 1'b1;
        tick();

        // CPU instruction read, minimum latency
        cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'h100; cpu_wstrb = 4'd0;
        tick();
        chk("rd_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_mem_instr", {31'd0, mem_instr}, 32'd1);
        chk("rd_early_ready", {31'd0, cpu_ready}, 32'd0);
        tick();
        chk("rd_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rd_cpu_rdata", cpu_rdata, 32'h12345678);
        chk("rd_mem_valid_resp", {31'd0, mem_valid}, 32'd0);
        cpu_valid = 1'b0;
        tick();
        chk("rd_ready_pulse", {31'd0, cpu_ready}, 32'd0);

        // Simultaneous CPU and debug requests
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h104; cpu_wstrb = 4'd0;
        dbg_valid = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'h000000A5; dbg_wstrb = 4'b0001;
        tick();
        chk("pri_mem_addr", mem_addr, 32'h200);
        chk("pri_mem_wdata", mem_wdata, 32'h000000A5);
        chk("pri_mem_wstrb", {28'd0, mem_wstrb}, 32'd1);
        chk("pri_mem_instr", {31'd0, mem_instr}, 32'd0);
        tick();
        chk("pri_dbg_ready", {31'd0, dbg_ready}, 32'd1);
        chk("pri_cpu_not_ready", {31'd0, cpu_ready}, 32'd0);
        chk("pri_dbg_rdata", dbg_rdata, ~32'h200);
`ifndef ARB_FAIR_EN
        dbg_valid = 1'b0;
`endif
        tick();
        chk("pri_idle_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("pri_write_commit", mem_rd(32'h200), 32'hFFFFFDA5);
        tick();
        chk("pri_cpu_grant", mem_addr, 32'h104);
        tick();
        chk("pri_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("pri_cpu_rdata", cpu_rdata, ~32'h104);
        cpu_valid = 1'b0;
`ifdef ARB_FAIR_EN
        tick(); tick();
        chk("fair_dbg_regrant", mem_addr, 32'h200);
        tick();
        chk("fair_dbg_ready", {31'd0, dbg_ready}, 32'd1);
        chk("fair_dbg_rdata", dbg_rdata, 32'hFFFFFDA5);
        dbg_valid = 1'b0;
`endif
        tick();

        // Debug halt during a CPU transfer
        cpu_valid = 1'b1; cpu_addr = 32'h108; cpu_wstrb = 4'd0;
        tick();
        chk("halt_mem_addr", mem_addr, 32'h108);
        dbg_halt = 1'b1;
        tick();
        chk("halt_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("halt_not_yet", {31'd0, cpu_halted}, 32'd0);
        tick();
        chk("halt_halted", {31'd0, cpu_halted}, 32'd1);
        chk("halt_no_grant", {31'd0, mem_valid}, 32'd0);
        n_dbg = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                dbg_valid = 1'b1; dbg_addr = 32'h300; dbg_wstrb = 4'd0;
            end
            tick();
            chk("halt_cpu_blocked", {31'd0, cpu_ready}, 32'd0);
            chk("halt_held", {31'd0, cpu_halted}, 32'd1);
            if (mem_valid) chk("halt_dbg_addr", mem_addr, 32'h300);
            if (dbg_ready) begin
                n_dbg++;
                chk("halt_dbg_rdata", dbg_rdata, ~32'h300);
                dbg_valid = 1'b0;
            end
        end
        chk("halt_dbg_served", 32'(n_dbg), 32'd1);
        dbg_halt = 1'b0;
        tick();
        chk("unhalt_grant", {31'd0, mem_valid}, 32'd1);
        chk("unhalt_addr", mem_addr, 32'h108);
        chk("unhalt_released", {31'd0, cpu_halted}, 32'd0);
        wait_rdy(1'b0, 5, "unhalt_cpu_ready");
        chk("unhalt_cpu_rdata", cpu_rdata, ~32'h108);
        cpu_valid = 1'b0;
        tick();

        // Memory stall leading to timeout abort
        mem_hold = 1'b1;
        cpu_valid = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h11; cpu_wstrb = 4'hF;
        tick();
        chk("to_mem_valid", {31'd0, mem_valid}, 32'd1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("to_still_valid", {31'd0, mem_valid}, 32'd1);
            chk("to_no_ready", {31'd0, cpu_ready}, 32'd0);
        end
        tick();
        chk("to_mem_dropped", {31'd0, mem_valid}, 32'd0);
        chk("to_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("to_err_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("to_err_flag", {31'd0, timeout_err}, 32'd1);
        cpu_valid = 1'b0; mem_hold = 1'b0;
        tick();
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("to_ready_pulse", {31'd0, cpu_ready}, 32'd0);
        chk("to_no_write", {31'd0, mem.exists(32'h400)}, 32'd0);

        // Reset in the middle of a debug transfer
        mem_hold = 1'b1;
        dbg_valid = 1'b1; dbg_addr = 32'h500; dbg_wstrb = 4'd0;
        tick();
        chk("rx_mem_valid", {31'd0, mem_valid}, 32'd1);
        resetn = 1'b0;
        tick();
        chk("rx_mem_valid_clr", {31'd0, mem_valid}, 32'd0);
        chk("rx_dbg_ready", {31'd0, dbg_ready}, 32'd0);
        chk("rx_err_clr", {31'd0, timeout_err}, 32'd0);
        resetn = 1'b1; mem_hold = 1'b0;
        tick();
        chk("rx_regrant", {31'd0, mem_valid}, 32'd1);
        chk("rx_regrant_addr", mem_addr, 32'h500);
        tick();
        chk("rx_dbg_ready2", {31'd0, dbg_ready}, 32'd1);
        chk("rx_dbg_rdata", dbg_rdata, ~32'h500);
        dbg_valid = 1'b0;
        tick();

        // Random traffic against the transaction model
        last_dbg = 1'b1;
        prev_mv = 1'b0;
        rand_wait = 1'b1;
        for (int i = 0; i < 500; i++) rnd_cycle(1'b1);
        for (int i = 0; i < 60; i++) rnd_cycle(1'b0);
        chk("rnd_drained", {31'd0, cpu_valid | dbg_valid}, 32'd0);
        chk("rnd_progress", {31'd0, n_done >= 30}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the simulation memory model between the picorv32 native memory port and the GDB-server debug access port.
- Grants one requester at a time, registers the winner's request onto the memory port, and returns rdata/ready to the owner.
- Lets the debugger halt CPU memory traffic, and aborts transfers that stall on the memory side.
- Sits between the cpu instance and the memory model in the top-level wrapper.

Parameters:
- TIMEOUT, 1024: mem_ready-low cycles allowed in a transfer before abort; legal range 1..65535.
- ERR_RDATA, 32'hDEADBEEF: rdata returned to the owner on a timed-out transfer.

Ports:
- clk  in  1  clock; all state on rising edge
- resetn  in  1  synchronous reset, active low
- cpu_valid  in  1  CPU request
- cpu_instr  in  1  CPU instruction-fetch qualifier
- cpu_addr  in  32  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_wstrb  in  4  CPU byte strobes; 0 means read
- cpu_ready  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  32  CPU read data; valid while cpu_ready=1
- dbg_valid, dbg_addr[32], dbg_wdata[32], dbg_wstrb[4]  in  debug request, same meaning as the CPU fields
- dbg_ready  out  1  one-cycle completion pulse to debug port
- dbg_rdata  out  32  debug read data; valid while dbg_ready=1
- dbg_halt  in  1  when 1, no new CPU grants
- cpu_halted  out  1  dbg_halt=1 and no CPU transfer owned
- mem_valid  out  1  registered request to the memory model
- mem_instr  out  1  registered copy of the owner's instr bit (0 for debug)
- mem_addr, mem_wdata  out  32  registered request fields
- mem_wstrb  out  4  registered byte strobes
- mem_ready  in  1  memory accepts/completes in the same cycle
- mem_rdata  in  32  memory read data, valid with mem_ready
- timeout_err  out  1  sticky; set on any abort

Behaviour:
- States: IDLE, CPU_XFER, DBG_XFER, RESP. Reset (resetn=0 at an edge) forces IDLE and clears all outputs to 0, including the timeout counter and timeout_err. Reset is honoured mid-transfer; the owner receives no ready pulse.
- IDLE arbitration at each edge:
  - dbg_valid=1: go to DBG_XFER.
  - Else cpu_valid=1 and dbg_halt=0: go to CPU_XFER.
  - Else stay in IDLE.
  - Strict debug priority in the base build.
- On grant, latch the owner's addr/wdata/wstrb/instr into the mem_* registers and set mem_valid=1. mem_* fields stay stable while mem_valid=1.
- XFER state with mem_ready=1 at an edge:
  - mem_valid drops to 0.
  - Owner's rdata register loads mem_rdata, including on writes.
  - Owner's ready pulses for exactly the next cycle (RESP), then go to IDLE.
- Minimum latency: valid sampled at edge 0, mem_valid high in cycle 1, mem_ready in cycle 1, owner ready in cycle 2. Three cycles request to ready.
- Timeout counter:
  - Clears on grant; increments each XFER cycle with mem_ready=0.
  - When it reaches TIMEOUT: mem_valid drops, owner rdata=ERR_RDATA, owner ready pulses in RESP, timeout_err=1 until reset.
  - No memory write is guaranteed in this case.
- Requester rule: valid is deasserted at the edge ending its ready cycle, or held to issue a new request. The IDLE state after RESP samples the new value. An unchanged held request is treated as a new request.
- dbg_halt:
  - Asserted during CPU_XFER, the CPU transfer completes normally.
  - cpu_halted rises in the cycle after the CPU RESP cycle and is combinational from dbg_halt and state otherwise.
  - While halted, debug requests are still served.
- cpu_ready and dbg_ready are never both 1. mem_valid is 0 in IDLE and RESP.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined: one-bit "last owner was debug" flag. In IDLE with both requests valid and dbg_halt=0, the CPU wins if the previous grant was debug; otherwise debug wins. The flag clears on reset.
- Undefined: strict debug priority as above; the flag is not implemented.

Test Plan:
- CPU read of addr 0x100, memory returns 0x12345678 with mem_ready in first XFER cycle -> mem_addr=0x100, mem_instr follows cpu_instr, cpu_ready one cycle at cycle 2 with cpu_rdata=0x12345678.
- cpu_valid and dbg_valid rise in the same cycle (debug write 0xA5 strobe 4'b0001 to 0x200) -> debug granted first, CPU granted in the IDLE after debug RESP. With ARB_FAIR_EN defined, a second back-to-back debug request loses to the pending CPU.
- dbg_halt=1 mid CPU transfer -> transfer finishes, cpu_halted=1 next cycle. New cpu_valid not granted for 20 cycles while a debug read of 0x300 completes. Drop halt -> CPU granted at the next IDLE edge.
- TIMEOUT=8, mem_ready held 0 -> after 8 XFER cycles mem_valid=0, cpu_ready pulses with cpu_rdata=0xDEADBEEF, timeout_err=1 and stays 1.
- resetn=0 for one edge during DBG_XFER -> next cycle mem_valid=0, dbg_ready=0, timeout_err=0, state IDLE; the pending debug request is re-granted after reset release.
